col_hist_buffer: RTL and testbench

//  Upstream feeder of the per-pixel line interpolator: turns a stream of raw sensor samples into
//  the packed N_COLS x 8-bit column-height vector (col_hs) the interpolator draws each frame.

---
 rtl/col_hist_buffer.sv | 81 ++++++++
 tb/tb_col_hist_buffer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/col_hist_buffer.sv
// col_hist_buffer: block-averages samples into clamped column heights, scrolls history, commits tear-free at frame start
module col_hist_buffer #(
  parameter int N_COLS   = 20,
  parameter int SCREEN_H = 480,
  parameter int IN_W     = 12,
  parameter int AVG_LOG2 = 2,
  parameter int SCALE_SH = 4,
  localparam int NB      = $clog2(N_COLS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_W-1:0]     s_data,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                frame_start,
  input  logic                freeze,
  output logic [8*N_COLS-1:0] col_hs,
  output logic [NB-1:0]       n_valid,
  output logic                upd
);
  localparam int H_MAX = SCREEN_H / 2 - 1;
  localparam int AW = IN_W + AVG_LOG2;
  localparam int CW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  localparam logic ACCUM = 1'b0;
  localparam logic PUSH  = 1'b1;
  logic                state_q, state_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [8*N_COLS-1:0] sh_q, sh_d, col_q, col_d;
  logic [NB-1:0]       shc_q, shc_d, nv_q, nv_d;
  logic                dirty_q, dirty_d, upd_q, upd_d;
  logic                xfer, last, push, commit;
  logic [AW-1:0]       avg, h;
  logic [7:0]          h8;
  assign s_ready = (state_q == ACCUM) & ~freeze & ~rst;
  assign xfer    = s_valid & s_ready;
  assign last    = cnt_q == CW'((1 << AVG_LOG2) - 1);
  assign push    = state_q == PUSH;
  assign commit  = frame_start & dirty_q;
  assign avg     = acc_q >> AVG_LOG2;
  assign h       = avg >> SCALE_SH;
  // clamp at full width so large averages cannot wrap into small heights
  assign h8      = (h > AW'(H_MAX)) ? 8'(H_MAX) : h[7:0];
  assign col_hs  = col_q;
  assign n_valid = nv_q;
  assign upd     = upd_q;
  always_comb begin
    state_d = push ? ACCUM : (xfer & last) ? PUSH : state_q;
    acc_d   = push ? '0 : xfer ? acc_q + AW'(s_data) : acc_q;
    cnt_d   = xfer ? (last ? '0 : cnt_q + CW'(1)) : cnt_q;
    sh_d    = push ? {h8, sh_q[8*N_COLS-1:8]} : sh_q;
    shc_d   = (push && shc_q != NB'(N_COLS)) ? shc_q + NB'(1) : shc_q;
    dirty_d = push | (dirty_q & ~frame_start);
    col_d   = commit ? sh_q : col_q;
    nv_d    = commit ? shc_q : nv_q;
    upd_d   = commit;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      shc_q   <= '0;
      dirty_q <= 1'b0;
      col_q   <= '0;
      nv_q    <= '0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      shc_q   <= shc_d;
      dirty_q <= dirty_d;
      col_q   <= col_d;
      nv_q    <= nv_d;
      upd_q   <= upd_d;
    end
  end
endmodule

// File: tb/tb_col_hist_buffer.sv
// tb_col_hist_buffer: randomized and directed checks of col_hist_buffer against a queue-based column model
module tb_col_hist_buffer;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [11:0]  s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic         frame_start = 1'b0;
  logic         freeze = 1'b0;
  logic [159:0] col_hs;
  logic [4:0]   n_valid;
  logic         upd;
  int checks = 0;
  int errors = 0;
  int samp[$];
  int hist[$];
  bit pend = 0;
  int pend_h = 0;
  bit dirty_m = 0;
  logic [159:0] exp_col = '0;
  int exp_nv = 0;
  bit exp_upd = 0;

  col_hist_buffer dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .frame_start(frame_start), .freeze(freeze), .col_hs(col_hs), .n_valid(n_valid), .upd(upd)
  );

  always #5 clk = ~clk;

  function automatic bit exp_ready();
    return !pend && !freeze && !rst;
  endfunction

  function automatic int height(input int sum);
    int v;
    v = (sum / 4) / 16;
    return v > 239 ? 239 : v;
  endfunction

  task automatic clear_model();
    samp.delete();
    hist.delete();
    pend = 0;
    dirty_m = 0;
    exp_col = '0;
    exp_nv = 0;
    exp_upd = 0;
  endtask

  // one clock: model advances from the inputs held across the rising edge; returns at the falling edge
  task automatic tick();
    bit x;
    bit fs;
    int sum;
    int idx;
    x = s_valid && exp_ready();
    fs = frame_start;
    @(posedge clk);
    if (!rst) begin
      exp_upd = fs && dirty_m;
      if (exp_upd) begin
        for (int k = 0; k < 20; k++) begin
          idx = hist.size() - 20 + k;
          exp_col[8*k +: 8] = idx >= 0 ? 8'(hist[idx]) : 8'd0;
        end
        exp_nv = hist.size();
        dirty_m = 0;
      end
      if (pend) begin
        hist.push_back(pend_h);
        if (hist.size() > 20) void'(hist.pop_front());
        dirty_m = 1;
        pend = 0;
      end
      if (x) begin
        samp.push_back(int'(s_data));
        if (samp.size() == 4) begin
          sum = 0;
          foreach (samp[i]) sum += samp[i];
          pend_h = height(sum);
          pend = 1;
          samp.delete();
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input int v);
    bit took;
    int n;
    s_valid = 1'b1;
    s_data = 12'(v);
    n = 0;
    do begin
      took = exp_ready();
      tick();
      n++;
    end while (!took && n < 200);
    if (!took) begin
      errors++;
      $display("FAIL send_timeout got no accept of %0d after %0d cycles", v, n);
    end
    s_valid = 1'b0;
  endtask

  task automatic send_col(input int hv);
    for (int i = 0; i < 4; i++) send(hv * 16);
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) send(1600);
    #1;
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_push got %b exp 0", s_ready); end
    tick();
    #1;
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after got %b exp 1", s_ready); end
    pulse_fs();
    checks++;
    if (col_hs[159:152] !== 8'd100) begin errors++; $display("FAIL basic_col19 got %0d exp 100", col_hs[159:152]); end
    checks++;
    if (n_valid !== 5'd1) begin errors++; $display("FAIL basic_nvalid got %0d exp 1", n_valid); end
    checks++;
    if (upd !== 1'b1 || exp_upd !== 1'b1) begin errors++; $display("FAIL basic_upd got %b exp 1", upd); end
    checks++;
    if (col_hs !== exp_col) begin errors++; $display("FAIL basic_col got %h exp %h", col_hs, exp_col); end
    tick();
    checks++;
    if (upd !== 1'b0) begin errors++; $display("FAIL basic_upd_pulse got %b exp 0", upd); end
  endtask

  task automatic test_clamp();
    for (int i = 0; i < 4; i++) send(4095);
    tick();
    pulse_fs();
    checks++;
    if (col_hs[159:152] !== 8'd239 || col_hs[151:144] !== 8'd100) begin
      errors++; $display("FAIL clamp_max got %0d,%0d exp 239,100", col_hs[159:152], col_hs[151:144]);
    end
    for (int i = 0; i < 4; i++) send(0);
    tick();
    pulse_fs();
    checks++;
    if (col_hs[159:152] !== 8'd0 || col_hs[151:144] !== 8'd239) begin
      errors++; $display("FAIL clamp_zero got %0d,%0d exp 0,239", col_hs[159:152], col_hs[151:144]);
    end
    checks++;
    if (col_hs !== exp_col || n_valid !== 5'(exp_nv)) begin
      errors++; $display("FAIL clamp_model got %h/%0d exp %h/%0d", col_hs, n_valid, exp_col, exp_nv);
    end
  endtask

  task automatic test_scroll();
    logic [159:0] held;
    bit bad;
    for (int v = 1; v <= 21; v++) send_col(v);
    tick();
    pulse_fs();
    bad = 0;
    for (int k = 0; k < 20; k++) if (col_hs[8*k +: 8] !== 8'(k + 2)) bad = 1;
    checks++;
    if (bad) begin errors++; $display("FAIL scroll_cols got %h exp k+2 per column", col_hs); end
    checks++;
    if (n_valid !== 5'd20 || exp_nv != 20) begin errors++; $display("FAIL scroll_nvalid got %0d exp 20", n_valid); end
    checks++;
    if (col_hs !== exp_col) begin errors++; $display("FAIL scroll_model got %h exp %h", col_hs, exp_col); end
    held = col_hs;
    bad = 0;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 4; i++) begin
        send(2000 + 100 * i);
        if (col_hs !== held || upd !== 1'b0) bad = 1;
      end
    end
    tick();
    checks++;
    if (bad || col_hs !== held) begin errors++; $display("FAIL scroll_hold got %h exp %h", col_hs, held); end
    pulse_fs();
    checks++;
    if (col_hs !== exp_col || upd !== 1'b1) begin errors++; $display("FAIL scroll_late got %h exp %h", col_hs, exp_col); end
  endtask

  task automatic test_fs_push();
    send_col(30);
    for (int i = 0; i < 4; i++) send(800);
    pulse_fs();
    checks++;
    if (upd !== 1'b1 || col_hs[159:152] !== 8'd30) begin
      errors++; $display("FAIL fspush_first got upd=%b col19=%0d exp upd=1 col19=30", upd, col_hs[159:152]);
    end
    tick();
    pulse_fs();
    checks++;
    if (upd !== 1'b1 || col_hs[159:152] !== 8'd50 || col_hs[151:144] !== 8'd30) begin
      errors++; $display("FAIL fspush_second got upd=%b col19=%0d exp upd=1 col19=50", upd, col_hs[159:152]);
    end
    checks++;
    if (col_hs !== exp_col) begin errors++; $display("FAIL fspush_model got %h exp %h", col_hs, exp_col); end
    tick();
    pulse_fs();
    checks++;
    if (upd !== 1'b0 || col_hs !== exp_col) begin errors++; $display("FAIL fspush_clean got upd=%b exp 0", upd); end
  endtask

  task automatic test_freeze();
    int acc_seen;
    send(1000);
    send(2000);
    freeze = 1'b1;
    s_valid = 1'b1;
    s_data = 12'd4095;
    acc_seen = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (s_ready !== 1'b0) acc_seen++;
      tick();
    end
    checks++;
    if (acc_seen != 0) begin errors++; $display("FAIL freeze_ready got %0d ready cycles exp 0", acc_seen); end
    freeze = 1'b0;
    s_valid = 1'b0;
    send(3000);
    send(4000);
    tick();
    pulse_fs();
    checks++;
    if (col_hs[159:152] !== 8'd156 || upd !== 1'b1) begin
      errors++; $display("FAIL freeze_avg got %0d exp 156", col_hs[159:152]);
    end
  endtask

  task automatic test_reset();
    send(4095);
    send(4095);
    #2;
    rst = 1'b1;
    #1;
    clear_model();
    checks++;
    if (col_hs !== '0 || n_valid !== 5'd0 || upd !== 1'b0) begin
      errors++; $display("FAIL reset_out got %h/%0d/%b exp 0/0/0", col_hs, n_valid, upd);
    end
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", s_ready); end
    @(negedge clk);
    tick();
    rst = 1'b0;
    send_col(30);
    tick();
    pulse_fs();
    checks++;
    if (col_hs !== {8'd30, 152'd0} || n_valid !== 5'd1) begin
      errors++; $display("FAIL reset_discard got %h/%0d exp col19=30 n=1", col_hs, n_valid);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        freeze = 1'b1;
        s_valid = 1'b1;
        repeat ($urandom_range(1, 4)) begin
          #1;
          if (s_ready !== exp_ready()) bad++;
          tick();
        end
        freeze = 1'b0;
        s_valid = 1'b0;
      end
      send($urandom_range(0, 4095));
      if ($urandom_range(0, 5) == 0) begin
        pulse_fs();
        checks++;
        if (col_hs !== exp_col || n_valid !== 5'(exp_nv) || upd !== exp_upd) begin
          errors++; $display("FAIL random_commit got %h/%0d/%b exp %h/%0d/%b", col_hs, n_valid, upd, exp_col, exp_nv, exp_upd);
        end
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL random_ready got %0d wrong cycles exp 0", bad); end
  endtask

  initial begin
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();
    test_basic();
    test_clamp();
    test_scroll();
    test_fs_push();
    test_freeze();
    test_random();
    test_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
